// File: rtl/pkg_delay_line.sv
// Stream delay line: each accepted beat is held until its per-packet release
// time arrives on a free-running wrap-safe timestamp, then drained in order.
module pkg_delay_line #(
  parameter int DATA_WIDTH = 512,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int DEPTH      = 64,
  parameter int TS_WIDTH   = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [TS_WIDTH-1:0]      io_delay_cycle,
  input  logic                     io_data_in_valid,
  output logic                     io_data_in_ready,
  input  logic [DATA_WIDTH-1:0]    io_data_in_bits_data,
  input  logic [KEEP_WIDTH-1:0]    io_data_in_bits_keep,
  input  logic                     io_data_in_bits_last,
  output logic                     io_data_out_valid,
  input  logic                     io_data_out_ready,
  output logic [DATA_WIDTH-1:0]    io_data_out_bits_data,
  output logic [KEEP_WIDTH-1:0]    io_data_out_bits_keep,
  output logic                     io_data_out_bits_last,
  output logic [$clog2(DEPTH):0]   io_occupancy,
  output logic [31:0]              io_pkts_in,
  output logic [31:0]              io_pkts_out
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;
  localparam logic [OW-1:0] FULL_CNT = OW'(DEPTH);

  logic [TS_WIDTH-1:0]   now_q;
  logic [TS_WIDTH-1:0]   dpkt_q;
  logic                  in_pkt_q;
  logic [AW-1:0]         wr_ptr_q;
  logic [AW-1:0]         rd_ptr_q;
  logic [OW-1:0]         occ_q;
  logic                  head_hold_q;
  logic [31:0]           pkts_in_q;
  logic [31:0]           pkts_out_q;

  logic [DATA_WIDTH-1:0] data_mem [DEPTH];
  logic [KEEP_WIDTH-1:0] keep_mem [DEPTH];
  logic                  last_mem [DEPTH];
  logic [TS_WIDTH-1:0]   rel_mem  [DEPTH];

  logic                  empty;
  logic                  push;
  logic                  pop;
  logic [TS_WIDTH-1:0]   d_eff;
  logic [TS_WIDTH-1:0]   head_diff;
  logic                  head_elig;

  assign empty     = (occ_q == '0);
  assign d_eff     = in_pkt_q ? dpkt_q : io_delay_cycle;
  assign head_diff = now_q - rel_mem[rd_ptr_q];
  assign head_elig = ~head_diff[TS_WIDTH-1];

  assign io_data_in_ready  = reset & (occ_q != FULL_CNT);
  // head_hold keeps valid asserted under long stalls even if the signed
  // difference would eventually wrap negative again.
  assign io_data_out_valid = reset & ~empty & (head_elig | head_hold_q);

  assign push = io_data_in_valid & io_data_in_ready;
  assign pop  = io_data_out_valid & io_data_out_ready;

  assign io_data_out_bits_data = io_data_out_valid ? data_mem[rd_ptr_q] : '0;
  assign io_data_out_bits_keep = io_data_out_valid ? keep_mem[rd_ptr_q] : '0;
  assign io_data_out_bits_last = io_data_out_valid & last_mem[rd_ptr_q];

  assign io_occupancy = occ_q;
  assign io_pkts_in   = pkts_in_q;
  assign io_pkts_out  = pkts_out_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      now_q       <= '0;
      dpkt_q      <= '0;
      in_pkt_q    <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
      head_hold_q <= 1'b0;
      pkts_in_q   <= '0;
      pkts_out_q  <= '0;
    end else begin
      now_q <= now_q + TS_WIDTH'(1);

      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
        if (!in_pkt_q) dpkt_q <= io_delay_cycle;
        in_pkt_q <= ~io_data_in_bits_last;
        if (io_data_in_bits_last) pkts_in_q <= pkts_in_q + 32'd1;
      end

      if (pop) begin
        rd_ptr_q    <= rd_ptr_q + AW'(1);
        head_hold_q <= 1'b0;
        if (io_data_out_bits_last) pkts_out_q <= pkts_out_q + 32'd1;
      end else if (io_data_out_valid) begin
        head_hold_q <= 1'b1;
      end

      case ({push, pop})
        2'b10:   occ_q <= occ_q + OW'(1);
        2'b01:   occ_q <= occ_q - OW'(1);
        default: occ_q <= occ_q;
      endcase
    end
  end

  // Storage needs no reset: occupancy alone defines which entries are live.
  always_ff @(posedge clock) begin
    if (push) begin
      data_mem[wr_ptr_q] <= io_data_in_bits_data;
      keep_mem[wr_ptr_q] <= io_data_in_bits_keep;
      last_mem[wr_ptr_q] <= io_data_in_bits_last;
      rel_mem[wr_ptr_q]  <= now_q + d_eff;
    end
  end

endmodule

// File: tb/tb_pkg_delay_line.sv
// Directed bench for pkg_delay_line with a small buffer and 8-bit timestamps
// so that backpressure and timestamp wrap are reachable quickly.
module tb_pkg_delay_line;

  localparam int DW    = 32;
  localparam int KW    = 4;
  localparam int DEPTH = 4;
  localparam int TSW   = 8;

  logic            clock = 1'b0;
  logic            reset;
  logic [TSW-1:0]  io_delay_cycle;
  logic            io_data_in_valid;
  logic            io_data_in_ready;
  logic [DW-1:0]   io_data_in_bits_data;
  logic [KW-1:0]   io_data_in_bits_keep;
  logic            io_data_in_bits_last;
  logic            io_data_out_valid;
  logic            io_data_out_ready;
  logic [DW-1:0]   io_data_out_bits_data;
  logic [KW-1:0]   io_data_out_bits_keep;
  logic            io_data_out_bits_last;
  logic [2:0]      io_occupancy;
  logic [31:0]     io_pkts_in;
  logic [31:0]     io_pkts_out;

  pkg_delay_line #(
    .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .DEPTH(DEPTH), .TS_WIDTH(TSW)
  ) dut (
    .clock                 (clock),
    .reset                 (reset),
    .io_delay_cycle        (io_delay_cycle),
    .io_data_in_valid      (io_data_in_valid),
    .io_data_in_ready      (io_data_in_ready),
    .io_data_in_bits_data  (io_data_in_bits_data),
    .io_data_in_bits_keep  (io_data_in_bits_keep),
    .io_data_in_bits_last  (io_data_in_bits_last),
    .io_data_out_valid     (io_data_out_valid),
    .io_data_out_ready     (io_data_out_ready),
    .io_data_out_bits_data (io_data_out_bits_data),
    .io_data_out_bits_keep (io_data_out_bits_keep),
    .io_data_out_bits_last (io_data_out_bits_last),
    .io_occupancy          (io_occupancy),
    .io_pkts_in            (io_pkts_in),
    .io_pkts_out           (io_pkts_out)
  );

  always #5 clock = ~clock;

  // Reference cycle count: value of the design's timestamp in the current cycle.
  logic [TSW-1:0] tb_now;
  always @(posedge clock) tb_now <= !reset ? 8'd0 : 8'(tb_now + 8'd1);

  int n_chk  = 0;
  int n_pass = 0;
  int exp_pin  = 0;
  int exp_pout = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [KW-1:0] keep_of(input logic [DW-1:0] d);
    return d[KW-1:0] ^ 4'hA;
  endfunction

  task automatic idle_in();
    io_data_in_valid     = 1'b0;
    io_data_in_bits_data = '0;
    io_data_in_bits_keep = '0;
    io_data_in_bits_last = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic send_beat(input logic [DW-1:0] d, input logic lst, input logic [TSW-1:0] dly,
                           output logic [TSW-1:0] t_acc);
    bit done = 0;
    t_acc = '0;
    io_data_in_valid     = 1'b1;
    io_data_in_bits_data = d;
    io_data_in_bits_keep = keep_of(d);
    io_data_in_bits_last = lst;
    io_delay_cycle       = dly;
    for (int c = 0; c < 50 && !done; c++) begin
      if (io_data_in_ready) begin
        t_acc = tb_now;
        done  = 1;
      end
      @(negedge clock);
    end
    if (!done) check_val("send_timeout", 0, 1);
    if (lst) exp_pin++;
    idle_in();
  endtask

  // Expects out_ready=1; checks the first valid beat seen from now on.
  task automatic wait_out(input string tag, input logic [TSW-1:0] exp_t,
                          input logic [DW-1:0] exp_d, input logic exp_l);
    bit done = 0;
    for (int c = 0; c < 200 && !done; c++) begin
      if (io_data_out_valid) begin
        check_val({tag, "_time"}, tb_now, exp_t);
        check_val({tag, "_data"}, io_data_out_bits_data, exp_d);
        check_val({tag, "_keep"}, io_data_out_bits_keep, keep_of(exp_d));
        check_val({tag, "_last"}, io_data_out_bits_last, exp_l);
        if (io_data_out_bits_last) exp_pout++;
        done = 1;
      end
      @(negedge clock);
    end
    if (!done) check_val({tag, "_timeout"}, 0, 1);
  endtask

  task automatic wait_now(input logic [TSW-1:0] t);
    for (int c = 0; c < 300 && tb_now != t; c++) @(negedge clock);
    check_val("wait_now", tb_now, t);
  endtask

  task automatic check_counters(input string tag);
    check_val({tag, "_pkts_in"},  io_pkts_in,  exp_pin);
    check_val({tag, "_pkts_out"}, io_pkts_out, exp_pout);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [TSW-1:0] t0, t1, t2, t3, t4;
    int acc, got, seen;
    bit stable;

    reset = 1'b0;
    io_delay_cycle = '0;
    io_data_out_ready = 1'b0;
    idle_in();
    repeat (2) @(negedge clock);

    check_val("rst_in_ready",  io_data_in_ready,  0);
    check_val("rst_out_valid", io_data_out_valid, 0);
    check_val("rst_occupancy", io_occupancy, 0);
    check_val("rst_out_data",  {io_data_out_bits_data, io_data_out_bits_keep, io_data_out_bits_last}, 0);
    check_counters("rst");
    reset = 1'b1;
    io_data_out_ready = 1'b1;
    @(negedge clock);
    check_val("post_rst_in_ready", io_data_in_ready, 1);

    // Single beat, delay 10, accepted in cycle 5.
    wait_now(8'd5);
    send_beat(32'h1, 1'b1, 8'd10, t0);
    check_val("single_accept_t", t0, 8'd5);
    wait_out("single", 8'd15, 32'h1, 1'b1);
    check_counters("single");

    // Three-beat packet with delay changed mid-packet, then a one-beat packet.
    send_beat(32'h2, 1'b0, 8'd10, t0);
    send_beat(32'h3, 1'b0, 8'd3,  t1);
    send_beat(32'h4, 1'b1, 8'd3,  t2);
    send_beat(32'h5, 1'b1, 8'd3,  t3);
    check_val("b2b_t1", t1, 8'(t0 + 8'd1));
    check_val("b2b_t3", t3, 8'(t0 + 8'd3));
    check_val("b2b_occupancy", io_occupancy, 4);
    wait_out("pkt_b0", 8'(t0 + 8'd10), 32'h2, 1'b0);
    wait_out("pkt_b1", 8'(t0 + 8'd11), 32'h3, 1'b0);
    wait_out("pkt_b2", 8'(t0 + 8'd12), 32'h4, 1'b1);
    wait_out("hol",    8'(t0 + 8'd13), 32'h5, 1'b1);
    send_beat(32'h6, 1'b1, 8'd3, t4);
    wait_out("next_pkt", 8'(t4 + 8'd3), 32'h6, 1'b1);
    check_counters("b2b");

    // Mid-packet increase must not affect the second beat.
    send_beat(32'h31, 1'b0, 8'd2,  t0);
    send_beat(32'h32, 1'b1, 8'd20, t1);
    wait_out("latch_b0", 8'(t0 + 8'd2), 32'h31, 1'b0);
    wait_out("latch_b1", 8'(t0 + 8'd3), 32'h32, 1'b1);
    send_beat(32'h33, 1'b1, 8'd20, t2);
    wait_out("latch_new", 8'(t2 + 8'd20), 32'h33, 1'b1);

    // Zero delay gives one cycle of latency.
    send_beat(32'h40, 1'b1, 8'd0, t0);
    wait_out("delay0", 8'(t0 + 8'd1), 32'h40, 1'b1);

    // Timestamp wrap.
    wait_now(8'd250);
    send_beat(32'h55, 1'b1, 8'd20, t0);
    check_val("wrap_accept_t", t0, 8'd250);
    wait_out("wrap", 8'd14, 32'h55, 1'b1);
    check_counters("wrap");

    // Backpressure: six beats offered with the output stalled.
    io_data_out_ready = 1'b0;
    io_delay_cycle = 8'd0;
    acc = 0;
    stable = 1;
    for (int c = 0; c < 12; c++) begin
      io_data_in_valid     = 1'b1;
      io_data_in_bits_data = 32'h10 + 32'(acc);
      io_data_in_bits_keep = keep_of(32'h10 + 32'(acc));
      io_data_in_bits_last = (acc == 5);
      if (io_data_in_ready) begin
        if (acc == 5) exp_pin++;
        acc++;
      end
      if (c > 4 && (!io_data_out_valid || io_data_out_bits_data != 32'h10)) stable = 0;
      @(negedge clock);
    end
    check_val("bp_accepts",   acc, 4);
    check_val("bp_in_ready",  io_data_in_ready, 0);
    check_val("bp_occupancy", io_occupancy, 4);
    check_val("bp_stable",    stable, 1);
    io_data_out_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 40 && got < 6; c++) begin
      if (io_data_out_valid) begin
        check_val("bp_out_data", io_data_out_bits_data, 32'h10 + 32'(got));
        if (io_data_out_bits_last) exp_pout++;
        got++;
      end
      if (acc < 6) begin
        io_data_in_valid     = 1'b1;
        io_data_in_bits_data = 32'h10 + 32'(acc);
        io_data_in_bits_keep = keep_of(32'h10 + 32'(acc));
        io_data_in_bits_last = (acc == 5);
        if (io_data_in_ready) begin
          if (acc == 5) exp_pin++;
          acc++;
        end
      end else begin
        idle_in();
      end
      @(negedge clock);
    end
    idle_in();
    check_val("bp_out_count", got, 6);
    check_counters("bp");

    // Reset with a partial packet buffered.
    io_data_out_ready = 1'b0;
    send_beat(32'h61, 1'b0, 8'd5, t0);
    send_beat(32'h62, 1'b0, 8'd5, t1);
    send_beat(32'h63, 1'b0, 8'd5, t2);
    check_val("pre_rst_occupancy", io_occupancy, 3);
    reset = 1'b0;
    @(negedge clock);
    check_val("mid_rst_out_valid", io_data_out_valid, 0);
    check_val("mid_rst_in_ready",  io_data_in_ready, 0);
    reset = 1'b1;
    exp_pin = 0;
    exp_pout = 0;
    @(negedge clock);
    check_val("post_rst_occupancy", io_occupancy, 0);
    check_counters("post_rst");
    io_data_out_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 15; c++) begin
      if (io_data_out_valid) seen++;
      @(negedge clock);
    end
    check_val("post_rst_stale", seen, 0);
    send_beat(32'h77, 1'b1, 8'd2, t3);
    wait_out("post_rst_pkt", 8'(t3 + 8'd2), 32'h77, 1'b1);
    check_counters("final");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pkg_delay_line.md
Name: pkg_delay_line

Overview:
- Parametrised successor to the fixed-width packet delay stage: AXI-stream-style (valid/ready/data/keep/last) delay line.
- Holds every accepted beat until a runtime-programmable number of cycles has elapsed, then releases beats in order.
- Generalised over data width, buffer depth and timestamp width.
- Adds per-packet delay latching, wrap-safe timestamping, occupancy reporting and packet counters.
- Sits between a network-side stream source and the RDMA engine to emulate link latency.

Parameters:
- DATA_WIDTH, 512, stream data width in bits; multiple of 8.
- KEEP_WIDTH, DATA_WIDTH/8, byte-enable width.
- DEPTH, 64, beat buffer entries; power of two, at least 2.
- TS_WIDTH, 32, timestamp/counter width; io_delay_cycle must be less than 2^(TS_WIDTH-1).

Ports:
- clock  input  1  sole clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset).
- io_delay_cycle  input  TS_WIDTH  requested delay in cycles; sampled per packet.
- io_data_in_valid  input  1  input beat valid.
- io_data_in_ready  output  1  input beat accepted when valid&ready.
- io_data_in_bits_data  input  DATA_WIDTH  input payload.
- io_data_in_bits_keep  input  KEEP_WIDTH  input byte enables.
- io_data_in_bits_last  input  1  last beat of packet.
- io_data_out_valid  output  1  output beat valid.
- io_data_out_ready  input  1  downstream ready.
- io_data_out_bits_data  output  DATA_WIDTH  output payload.
- io_data_out_bits_keep  output  KEEP_WIDTH  output byte enables.
- io_data_out_bits_last  output  1  last flag, passed through unchanged.
- io_occupancy  output  log2(DEPTH)+1  beats currently buffered.
- io_pkts_in  output  32  count of input beats accepted with last=1; wraps.
- io_pkts_out  output  32  count of output beats transferred with last=1; wraps.

Behaviour:
- Reset (reset=0 at a rising edge):
  - buffer emptied, pointers and free-running cycle counter `now` set to 0, in-packet flag cleared;
  - io_data_in_ready=0, io_data_out_valid=0, io_occupancy=0, io_pkts_in=0, io_pkts_out=0;
  - data/keep/last outputs driven 0.
- Reset mid-operation discards all buffered beats; no partial packet is emitted after reset.
- Reset takes priority over every simultaneous handshake.
- `now` increments by 1 every cycle out of reset and wraps modulo 2^TS_WIDTH.
- io_data_in_ready = (occupancy < DEPTH), registered-state based only; it does not depend on io_data_out_ready (no same-cycle slot reuse when full).
- Delay latching:
  - The first beat of a packet is the first beat accepted while the in-packet flag is 0. It samples io_data_in_bits_delay... specifically io_data_in's companion io_delay_cycle into Dpkt and sets the flag.
  - The beat with last=1 clears the flag.
  - Every beat of the packet uses Dpkt; changes to io_delay_cycle mid-packet have no effect until the next packet.
- On accept in cycle t, the entry stores data, keep, last and release = (t + Dpkt) mod 2^TS_WIDTH.
- Head eligibility: head is eligible when the signed TS_WIDTH-bit difference (now - release) >= 0. This is wrap-safe.
- io_data_out_valid = buffer non-empty AND head eligible AND not in reset.
- Latency:
  - A beat accepted in cycle t first shows out_valid in cycle t + max(Dpkt, 1), provided all earlier beats have already left.
  - Dpkt=0 therefore gives 1-cycle latency.
- Ordering is strict FIFO. A later beat with a shorter delay waits behind the head (head-of-line blocking is intended).
- Once out_valid=1, data/keep/last stay stable until out_ready=1 (AXI rule); out_valid never drops without a transfer.
- Pop when out_valid&out_ready. Push and pop in the same cycle leave occupancy unchanged.
- Pointers: log2(DEPTH) bits, wrap naturally; full/empty decided from occupancy.
- io_pkts_in increments on an accepted last=1 beat; io_pkts_out increments on a transferred last=1 beat. Both are 32-bit wrapping counters.
- The block never modifies keep or last and never drops beats.

Test Plan:
- Single beat, delay 10: io_delay_cycle=10, last=1, data=0x1 accepted in cycle 5 -> out_valid first high in cycle 15, data=0x1, io_pkts_out=1 after transfer.
- Back-to-back 3-beat packet (data 0x2,0x3,0x4, last on 0x4), delay 10, with io_delay_cycle changed to 3 after beat 1 -> beats appear in cycles t0+10..t0+12, in order; the next packet uses delay 3.
- Delay 0: beat accepted in cycle t -> out_valid in cycle t+1.
- Backpressure: DEPTH=4, out_ready=0, 6 beats offered -> in_ready falls after 4 accepts, io_occupancy=4; raise out_ready -> all 6 beats emerge in order, data held stable while stalled.
- Timestamp wrap: TS_WIDTH=8, delay 20, beat accepted at now=250 -> released at now=14 (after wrap), not at 250.
- Reset mid-operation: 3 beats buffered, reset=0 for one cycle -> io_occupancy=0, out_valid=0, counters=0; no stale beat emitted afterwards.
